keypad_scanner: RTL and testbench

- Drives the row strobes of a 4x4 membrane keypad and samples its column returns.
- Debounces whole-matrix snapshots and reports single-key presses as a 4-bit code with a one-cycle strobe.
- Sits between the keypad pins and the user-input logic; it is the scanning, output-driving counterpart of the single-button debouncer on the input path.

---
 rtl/keypad_scanner.sv | 121 ++++++++++++
 tb/tb_keypad_scanner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes rows, snapshots column returns per full scan,
// debounces whole-matrix snapshots and emits a one-cycle strobe on single-key presses.
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [15:0] keys,
    output logic        key_held,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] STABLE_MAX = DW'(DEBOUNCE - 1);

    logic [3:0]    col_s1_q, col_s2_q;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    row_n_q, row_n_d;
    logic [15:0]   snap_q, snap_d;
    logic [15:0]   prev_q, prev_d;
    logic [DW-1:0] stable_q, stable_d;
    logic [15:0]   keys_q, keys_d;
    logic          held_q, held_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;

    logic [15:0]   snap_full;
    logic          one_hot;
    logic [3:0]    idx;

    always_comb begin
        slot_d    = slot_q + 1'b1;
        row_d     = row_q;
        row_n_d   = row_n_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        keys_d    = keys_q;
        held_d    = held_q;
        code_d    = code_q;
        valid_d   = 1'b0;

        // Snapshot including the row being sampled this cycle, so the row-3
        // compare sees the complete matrix on the same edge it is stored.
        snap_full = snap_q;
        snap_full[{row_q, 2'b00} +: 4] = ~col_s2_q;

        one_hot = (snap_full != '0) && ((snap_full & (snap_full - 16'd1)) == '0);
        idx     = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snap_full[i]) idx = 4'(i);
        end

        if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            row_d   = row_q + 2'd1;
            row_n_d = ~(4'b0001 << row_d);
            snap_d  = snap_full;
            if (row_q == 2'd3) begin
                prev_d = snap_full;
                if (snap_full != prev_q) begin
                    stable_d = '0;
                end else if (stable_q != STABLE_MAX) begin
                    stable_d = stable_q + 1'b1;
                end
                if (stable_d == STABLE_MAX) begin
                    keys_d = snap_full;
                    held_d = |snap_full;
                    if ((keys_q == '0) && one_hot) begin
                        code_d  = idx;
                        valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= '1;
            col_s2_q <= '1;
            slot_q   <= '0;
            row_q    <= '0;
            row_n_q  <= 4'b1110;
            snap_q   <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            keys_q   <= '0;
            held_q   <= 1'b0;
            code_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            col_s1_q <= col_n;
            col_s2_q <= col_s1_q;
            slot_q   <= slot_d;
            row_q    <= row_d;
            row_n_q  <= row_n_d;
            snap_q   <= snap_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            keys_q   <= keys_d;
            held_q   <= held_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
        end
    end

    assign row_n     = row_n_q;
    assign keys      = keys_q;
    assign key_held  = held_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed press/bounce/release
// sequences, and a scoreboard that checks each key_valid pulse and its cycle.
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] keys;
    logic        key_held;
    logic [3:0]  key_code;
    logic        key_valid;

    logic [15:0] pressed;
    int          cyc;
    int          total;
    int          bad;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] keys;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col_n    (col_n),
        .row_n    (row_n),
        .keys     (keys),
        .key_held (key_held),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Membrane matrix: a closed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] code, input logic [15:0] k, input int c);
        exp_t e;
        e.code = code;
        e.keys = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {28'd0, key_code}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_code", {28'd0, key_code}, {28'd0, e.code});
                chk("pulse_keys", {16'd0, keys}, {16'd0, e.keys});
                chk("pulse_held", {31'd0, key_held}, 32'd1);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the edge that starts a row-0 slot following row 3.
    task automatic wait_scan_start(output int s);
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (row_n != 4'b0111 && n < 100);
        do begin @(posedge clk); #1; n++; end while (row_n != 4'b1110 && n < 100);
        if (n >= 100) chk("scan_start_timeout", n, 0);
        s = cyc;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row_n"},     {28'd0, row_n},     32'hE);
        chk({tag, "_keys"},      {16'd0, keys},      32'h0);
        chk({tag, "_key_held"},  {31'd0, key_held},  32'h0);
        chk({tag, "_key_code"},  {28'd0, key_code},  32'h0);
        chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int n;
        logic [3:0] exp_row;
        total   = 0;
        bad     = 0;
        pressed = '0;
        rst_n   = 1'b0;

        // Reset and idle row sequencing
        wait_cycles(3);
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            exp_row = 4'hF ^ (4'h1 << ((k / 4) % 4));
            chk("row_seq", {28'd0, row_n}, {28'd0, exp_row});
        end
        chk("idle_keys", {16'd0, keys}, 32'h0);
        chk("idle_held", {31'd0, key_held}, 32'h0);

        // Single press of key 9 from a scan boundary
        wait_scan_start(s);
        pressed[9] = 1'b1;
        push_exp(4'd9, 16'h0200, s + 48);
        wait_cycles(64);
        chk("press_keys", {16'd0, keys}, 32'h0200);
        chk("press_held", {31'd0, key_held}, 32'h1);
        chk("press_code", {28'd0, key_code}, 32'h9);
        chk("press_sb_empty", exp_q.size(), 0);

        wait_scan_start(s);
        pressed[9] = 1'b0;
        wait_cycles(64);
        chk("rel1_keys", {16'd0, keys}, 32'h0);

        // Bounce: the row-2 sample of the third bouncing scan lands on an open phase
        wait_scan_start(s);
        wait_cycles(4);
        pressed[9] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_cycles(10);
            pressed[9] = ~pressed[9];
        end
        push_exp(4'd9, 16'h0200, s + 96);
        wait_cycles(80);
        chk("bounce_keys", {16'd0, keys}, 32'h0200);
        chk("bounce_sb_empty", exp_q.size(), 0);

        // Release, then press key 0
        wait_scan_start(s);
        pressed[9] = 1'b0;
        wait_cycles(64);
        chk("rel2_keys", {16'd0, keys}, 32'h0);
        chk("rel2_held", {31'd0, key_held}, 32'h0);
        wait_scan_start(s);
        pressed[0] = 1'b1;
        push_exp(4'd0, 16'h0001, s + 48);
        wait_cycles(64);
        chk("key0_keys", {16'd0, keys}, 32'h0001);
        chk("key0_sb_empty", exp_q.size(), 0);

        // Two-key press, then partial release
        wait_scan_start(s);
        pressed = '0;
        wait_cycles(64);
        wait_scan_start(s);
        pressed[5]  = 1'b1;
        pressed[15] = 1'b1;
        wait_cycles(64);
        chk("multi_keys", {16'd0, keys}, 32'h8020);
        chk("multi_held", {31'd0, key_held}, 32'h1);
        chk("multi_code", {28'd0, key_code}, 32'h0);
        wait_scan_start(s);
        pressed[15] = 1'b0;
        wait_cycles(64);
        chk("partial_keys", {16'd0, keys}, 32'h0020);
        chk("partial_held", {31'd0, key_held}, 32'h1);

        // Reset in the row-2 slot with key 9 committed
        wait_scan_start(s);
        pressed = '0;
        wait_cycles(64);
        wait_scan_start(s);
        pressed[9] = 1'b1;
        push_exp(4'd9, 16'h0200, s + 48);
        wait_cycles(64);
        chk("pre_rst_keys", {16'd0, keys}, 32'h0200);
        chk("pre_rst_code", {28'd0, key_code}, 32'h9);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (row_n != 4'b1011 && n < 100);
        if (n >= 100) chk("row2_timeout", n, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s = cyc;
        push_exp(4'd9, 16'h0200, s + 48);
        wait_cycles(64);
        chk("rearm_keys", {16'd0, keys}, 32'h0200);
        chk("rearm_held", {31'd0, key_held}, 32'h1);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
